// File: rtl/pc_sequencer.sv
// pc_sequencer: architectural PC, fetch handshake, next-PC/trap selection and retired-instruction counter
//
// Parameters:
//   XLEN          datapath / PC width
//   RESET_VECTOR  PC loaded on reset
//   TRAP_VECTOR   PC loaded when a control-flow target is misaligned
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   fetch_valid   out  fetch_pc is a valid fetch request (FETCH state)
//   fetch_ready   in   instruction memory accepts the request
//   fetch_pc      out  current PC
//   exec_done     in   execute stage finished; pc_src/rs1/imm/cmp_taken/is_rvc valid
//   pc_src        in   00 jalr, 01 jal, 10 branch, 11 sequential
//   rs1, imm      in   jalr base, sign-extended offset
//   cmp_taken     in   branch condition result
//   is_rvc        in   current instruction is 16-bit (only with PC_RVC_EN)
//   link_addr     out  PC + step (return address)
//   trap_valid    out  one-cycle pulse on a misaligned-target trap
//   trap_epc      out  PC of the trapping instruction
//   trap_tval     out  offending target address
//   instret       out  instructions retired without trap
//
// Build option: define PC_RVC_EN to enable compressed (16-bit) instruction support.
module pc_sequencer #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(32'h10)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] fetch_pc,
  input  logic            exec_done,
  input  logic [1:0]      pc_src,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] imm,
  input  logic            cmp_taken,
  input  logic            is_rvc,
  output logic [XLEN-1:0] link_addr,
  output logic            trap_valid,
  output logic [XLEN-1:0] trap_epc,
  output logic [XLEN-1:0] trap_tval,
  output logic [63:0]     instret
);
  typedef enum logic [1:0] {BOOT, FETCH, EXEC} state_t;
  state_t state, state_nxt;
  logic [XLEN-1:0] pc, step, target, rs1_sum, pc_sum;
  logic retire, jump, misaligned;
`ifdef PC_RVC_EN
  assign step = is_rvc ? XLEN'(2) : XLEN'(4);
`else
  logic unused_rvc;
  assign unused_rvc = is_rvc;
  assign step = XLEN'(4);
`endif
  assign fetch_pc = pc;
  assign link_addr = pc + step;
  always_comb begin
    state_nxt = state;
    fetch_valid = 1'b0;
    retire = 1'b0;
    case (state)
      BOOT: state_nxt = FETCH;
      FETCH: begin
        fetch_valid = 1'b1;
        state_nxt = fetch_ready ? EXEC : FETCH;
      end
      EXEC: begin
        retire = exec_done;
        state_nxt = exec_done ? FETCH : EXEC;
      end
      default: state_nxt = BOOT;
    endcase
  end
  // Only jalr, jal and taken branches are alignment-checked; fall-through never traps.
  always_comb begin
    rs1_sum = rs1 + imm;
    pc_sum = pc + imm;
    jump = (pc_src == 2'b00) || (pc_src == 2'b01) || (pc_src == 2'b10 && cmp_taken);
    target = (pc_src == 2'b00) ? {rs1_sum[XLEN-1:1], 1'b0} : jump ? pc_sum : link_addr;
`ifdef PC_RVC_EN
    misaligned = jump && target[0];
`else
    misaligned = jump && (target[1:0] != 2'b00);
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
      pc <= RESET_VECTOR;
      trap_valid <= 1'b0;
      trap_epc <= '0;
      trap_tval <= '0;
      instret <= '0;
    end else begin
      state <= state_nxt;
      trap_valid <= retire && misaligned;
      if (retire && misaligned) begin
        pc <= TRAP_VECTOR;
        trap_epc <= pc;
        trap_tval <= target;
      end else if (retire) begin
        pc <= target;
        instret <= instret + 64'd1;
      end
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed plus randomized check of pc_sequencer against a next-PC reference model
module tb_pc_sequencer;
  localparam logic [31:0] RV = 32'h100;
  localparam logic [31:0] TV = 32'h10;
`ifdef PC_RVC_EN
  localparam bit RVC_EN = 1'b1;
`else
  localparam bit RVC_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic fetch_valid, fetch_ready = 1'b0, exec_done = 1'b0, cmp_taken = 1'b0, is_rvc = 1'b0, trap_valid;
  logic [1:0] pc_src = 2'b11;
  logic [31:0] fetch_pc, rs1 = '0, imm = '0, link_addr, trap_epc, trap_tval;
  logic [63:0] instret;
  int n_cmp = 0, n_fail = 0;
  logic [31:0] m_pc, m_epc, m_tval;
  logic [63:0] m_instret;

  pc_sequencer #(.XLEN(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_pc(fetch_pc), .exec_done(exec_done), .pc_src(pc_src), .rs1(rs1), .imm(imm),
    .cmp_taken(cmp_taken), .is_rvc(is_rvc), .link_addr(link_addr), .trap_valid(trap_valid),
    .trap_epc(trap_epc), .trap_tval(trap_tval), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One instruction: optional backpressure, handshake, optional execute latency, then resolve.
  task automatic run_instr(input logic [1:0] src, input logic [31:0] r, input logic [31:0] im,
                           input logic tk, input logic rv, input int bp, input int ed);
    logic [31:0] stp, tgt, expl;
    bit jmp, trap;
    check("fetch_valid", fetch_valid, 1);
    check("fetch_pc", fetch_pc, m_pc);
    for (int i = 0; i < bp; i++) begin
      fetch_ready = 1'b0;
      exec_done = 1'($urandom_range(0, 1));
      pc_src = 2'($urandom);
      @(posedge clk); #1;
      check("bp_pc", fetch_pc, m_pc);
      check("bp_valid", fetch_valid, 1);
      check("bp_trap", trap_valid, 0);
    end
    exec_done = 1'b0;
    fetch_ready = 1'b1;
    @(posedge clk); #1;
    fetch_ready = 1'b0;
    check("exec_valid", fetch_valid, 0);
    check("trap_pulse_end", trap_valid, 0);
    for (int i = 0; i < ed; i++) begin
      @(posedge clk); #1;
      check("exec_wait", fetch_valid, 0);
      check("exec_wait_pc", fetch_pc, m_pc);
    end
    pc_src = src; rs1 = r; imm = im; cmp_taken = tk; is_rvc = rv; exec_done = 1'b1;
    stp = (RVC_EN && rv) ? 32'd2 : 32'd4;
    expl = m_pc + stp;
    case (src)
      2'b00: begin tgt = (r + im) & 32'hFFFF_FFFE; jmp = 1; end
      2'b01: begin tgt = m_pc + im; jmp = 1; end
      2'b10: begin tgt = tk ? m_pc + im : m_pc + stp; jmp = tk; end
      default: begin tgt = m_pc + stp; jmp = 0; end
    endcase
    trap = jmp && (tgt % (RVC_EN ? 32'd2 : 32'd4) != 0);
    #1;
    check("link_addr", link_addr, expl);
    @(posedge clk); #1;
    exec_done = 1'b0;
    if (trap) begin
      m_epc = m_pc; m_tval = tgt; m_pc = TV;
    end else begin
      m_pc = tgt; m_instret = m_instret + 1;
    end
    check("next_pc", fetch_pc, m_pc);
    check("next_valid", fetch_valid, 1);
    check("trap_valid", trap_valid, trap);
    check("trap_epc", trap_epc, m_epc);
    check("trap_tval", trap_tval, m_tval);
    check("instret", instret, m_instret);
  endtask

  initial begin
    m_pc = RV; m_epc = 0; m_tval = 0; m_instret = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", fetch_valid, 0);
    check("rst_pc", fetch_pc, RV);
    check("rst_instret", instret, 0);
    check("rst_trap", trap_valid, 0);
    check("rst_epc", trap_epc, 0);
    check("rst_tval", trap_tval, 0);
    rst = 1'b0;
    check("boot_valid", fetch_valid, 0);
    @(posedge clk); #1;
    check("first_valid", fetch_valid, 1);
    check("first_pc", fetch_pc, RV);
    run_instr(2'b11, 0, 0, 0, 0, 5, 0);
    check("seq_pc_104", fetch_pc, 32'h104);
    check("seq_instret_1", instret, 1);
    run_instr(2'b00, 32'h200, 0, 0, 0, 0, 0);
    run_instr(2'b01, 0, 32'hFFFF_FFF8, 0, 0, 0, 1);
    check("jal_1f8", fetch_pc, 32'h1F8);
    run_instr(2'b00, 32'h200, 0, 0, 0, 0, 0);
    run_instr(2'b10, 0, 32'h40, 1, 0, 1, 0);
    check("br_taken_240", fetch_pc, 32'h240);
    run_instr(2'b00, 32'h200, 0, 0, 0, 0, 0);
    run_instr(2'b10, 0, 32'h40, 0, 0, 0, 2);
    check("br_not_204", fetch_pc, 32'h204);
    run_instr(2'b00, 32'h301, 0, 0, 0, 0, 0);
    check("jalr_300", fetch_pc, 32'h300);
    run_instr(2'b00, 32'h200, 0, 0, 0, 0, 0);
    run_instr(2'b00, 32'h302, 0, 0, 0, 0, 0);
    check("mis_pc", fetch_pc, RVC_EN ? 32'h302 : TV);
    run_instr(2'b00, 32'h200, 0, 0, 0, 0, 0);
    run_instr(2'b10, 0, 32'h6, 0, 0, 0, 0);
    check("br6_not_204", fetch_pc, 32'h204);
    run_instr(2'b00, 32'h200, 0, 0, 0, 0, 0);
    run_instr(2'b11, 0, 0, 0, 1, 0, 0);
    check("rvc_seq", fetch_pc, RVC_EN ? 32'h202 : 32'h204);
    run_instr(2'b00, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
    run_instr(2'b11, 0, 0, 0, 0, 0, 0);
    check("wrap_pc", fetch_pc, 0);
    for (int n = 0; n < 300; n++) begin
      logic [31:0] r, im;
      r = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      im = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      run_instr(2'($urandom), r, im, 1'($urandom), 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
    end
    check("fetch_before_rst", fetch_valid, 1);
    fetch_ready = 1'b1;
    @(posedge clk); #1;
    fetch_ready = 1'b0;
    pc_src = 2'b11; exec_done = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    exec_done = 1'b0;
    check("rst_exec_pc", fetch_pc, RV);
    check("rst_exec_instret", instret, 0);
    check("rst_exec_valid", fetch_valid, 0);
    check("rst_exec_trap", trap_valid, 0);
    check("rst_exec_epc", trap_epc, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("reboot_valid", fetch_valid, 1);
    check("reboot_pc", fetch_pc, RV);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
